// File: rtl/and4_sweep_pkg.sv
// Shared types and helpers for the 4-input AND gate sweep driver.
package and4_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

    // Number of distinct input vectors for an n_in-input gate.
    function automatic int unsigned nvec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that holds each stimulus vector for SETTLE_CYC cycles.
module sweep_settle_timer #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero_c
);

    localparam int unsigned W = $clog2(SETTLE_CYC) + 1;
    localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYC - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/and4_sweep_driver.sv
// Exhaustive ascending-vector sweep of an AND gate with golden compare and error count.
// Define SWEEP_ERRLOG_EN to add the first_err_vec capture register and port.
module and4_sweep_driver
    import and4_sweep_pkg::*;
#(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_o,
    output logic [N_IN-1:0] vec_o,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt
`ifdef SWEEP_ERRLOG_EN
    ,
    output logic [N_IN-1:0] first_err_vec
`endif
);

    localparam int unsigned     ERR_W    = N_IN + 1;
    localparam int unsigned     NVEC     = nvec(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic            pass_q, pass_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tmr_load;
    logic            tmr_dec;
    logic            tmr_zero_c;
    logic            mismatch_c;
`ifdef SWEEP_ERRLOG_EN
    logic [N_IN-1:0] first_err_q, first_err_d;
`endif

    sweep_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .dec    (tmr_dec),
        .zero_c (tmr_zero_c)
    );

    // Golden model: the gate output must equal the reduction-AND of the stimulus.
    assign mismatch_c = (dut_o != (&vec_q));

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        err_cnt_d = err_cnt_q;
        pass_d    = pass_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
`ifdef SWEEP_ERRLOG_EN
        first_err_d = first_err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SETTLE;
                    vec_d     = '0;
                    err_cnt_d = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    tmr_load  = 1'b1;
`ifdef SWEEP_ERRLOG_EN
                    first_err_d = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (tmr_zero_c) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
`ifdef SWEEP_ERRLOG_EN
                    if (err_cnt_q == '0) begin
                        first_err_d = vec_q;
                    end
`endif
                end
                // Terminal vector always ends the sweep; the index never wraps.
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d  = SETTLE;
                    vec_d    = vec_q + N_IN'(1);
                    tmr_load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef SWEEP_ERRLOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_err_q <= '0;
        end else begin
            first_err_q <= first_err_d;
        end
    end

    assign first_err_vec = first_err_q;
`endif

    assign vec_o   = vec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_and4_sweep_driver.sv
// Scoreboard bench for and4_sweep_driver: default build plus a SETTLE_CYC=3 instance.
module tb_and4_sweep_driver;

    typedef struct {
        int   cycles;
        int   err;
        logic pass;
        int   first;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic [1:0] mode1 = 2'd0;
    logic       dut_o1;
    logic       dut_o3;
    logic [3:0] vec1, vec3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [4:0] err1, err3;
`ifdef SWEEP_ERRLOG_EN
    logic [3:0] ferr1, ferr3;
`endif

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t1 = 0;
    int   t3 = 0;
    logic busy1_prev = 1'b0;
    logic busy3_prev = 1'b0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t em;

    always #5 clk = ~clk;

    // Gate model: 0 = good AND, 1 = stuck-at-0, 2 = stuck-at-1.
    assign dut_o1 = (mode1 == 2'd0) ? (&vec1) : (mode1 == 2'd1) ? 1'b0 : 1'b1;
    assign dut_o3 = &vec3;

    and4_sweep_driver #(.N_IN(4), .SETTLE_CYC(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .dut_o   (dut_o1),
        .vec_o   (vec1),
        .busy    (busy1),
        .done    (done1),
        .pass    (pass1),
        .err_cnt (err1)
`ifdef SWEEP_ERRLOG_EN
        ,
        .first_err_vec (ferr1)
`endif
    );

    and4_sweep_driver #(.N_IN(4), .SETTLE_CYC(3)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start3),
        .dut_o   (dut_o3),
        .vec_o   (vec3),
        .busy    (busy3),
        .done    (done3),
        .pass    (pass3),
        .err_cnt (err3)
`ifdef SWEEP_ERRLOG_EN
        ,
        .first_err_vec (ferr3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push1(input int cycles, input int err, input logic pass, input int first);
        exp_t e;
        e.cycles = cycles; e.err = err; e.pass = pass; e.first = first;
        q1.push_back(e);
    endtask

    task automatic push3(input int cycles, input int err, input logic pass, input int first);
        exp_t e;
        e.cycles = cycles; e.err = err; e.pass = pass; e.first = first;
        q3.push_back(e);
    endtask

    task automatic pulse_start1();
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
    endtask

    task automatic wait_done1();
        int n;
        n = 0;
        while (!done1 && n < 200) begin @(negedge clk); n++; end
        chk("dut1_done_seen", 32'(done1), 32'd1);
    endtask

    task automatic wait_done3();
        int n;
        n = 0;
        while (!done3 && n < 300) begin @(negedge clk); n++; end
        chk("dut3_done_seen", 32'(done3), 32'd1);
    endtask

    task automatic wait_vec1(input logic [3:0] v);
        int n;
        n = 0;
        while (vec1 !== v && n < 100) begin @(negedge clk); n++; end
        chk("dut1_reach_vec", 32'(vec1), 32'(v));
    endtask

    // Monitor: tracks sweep start (busy rise) and checks every done pulse against the queues.
    always @(negedge clk) begin
        cyc++;
        if (busy1 && !busy1_prev) t1 = cyc;
        if (busy3 && !busy3_prev) t3 = cyc;
        busy1_prev = busy1;
        busy3_prev = busy3;
        if (done1) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL dut1_unexpected_done: got done=1 expected no pending sweep at cycle %0d", cyc);
            end else begin
                em = q1.pop_front();
                chk("dut1_sweep_cycles", 32'(cyc - t1), 32'(em.cycles));
                chk("dut1_err_cnt", 32'(err1), 32'(em.err));
                chk("dut1_pass", 32'(pass1), 32'(em.pass));
                chk("dut1_busy_in_done", 32'(busy1), 32'd0);
`ifdef SWEEP_ERRLOG_EN
                chk("dut1_first_err_vec", 32'(ferr1), 32'(em.first));
`endif
            end
        end
        if (done3) begin
            if (q3.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL dut3_unexpected_done: got done=1 expected no pending sweep at cycle %0d", cyc);
            end else begin
                em = q3.pop_front();
                chk("dut3_sweep_cycles", 32'(cyc - t3), 32'(em.cycles));
                chk("dut3_err_cnt", 32'(err3), 32'(em.err));
                chk("dut3_pass", 32'(pass3), 32'(em.pass));
`ifdef SWEEP_ERRLOG_EN
                chk("dut3_first_err_vec", 32'(ferr3), 32'(em.first));
`endif
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #10;
        chk("rst_vec", 32'(vec1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_pass", 32'(pass1), 32'd0);
        chk("rst_err_cnt", 32'(err1), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: good gate, vector stepping 0..F at two cycles per vector.
        mode1 = 2'd0;
        push1(32, 0, 1'b1, 0);
        pulse_start1();
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            chk("t1_vec_step", 32'(vec1), 32'(k / 2));
        end
        wait_done1();
        repeat (3) @(negedge clk);
        chk("t1_hold_pass", 32'(pass1), 32'd1);
        chk("t1_hold_err", 32'(err1), 32'd0);
        chk("t1_hold_vec", 32'(vec1), 32'hF);
        chk("t1_idle_done", 32'(done1), 32'd0);

        // 2: stuck-at-0 only disagrees at vector F.
        mode1 = 2'd1;
        push1(32, 1, 1'b0, 'hF);
        pulse_start1();
        chk("t2_start_clears_err", 32'(err1), 32'd0);
        wait_done1();
        @(negedge clk);

        // 3: stuck-at-1 disagrees at every vector except F.
        mode1 = 2'd2;
        push1(32, 15, 1'b0, 'h0);
        pulse_start1();
        wait_done1();
        repeat (2) @(negedge clk);
        chk("t3_hold_err", 32'(err1), 32'd15);
        chk("t3_hold_pass", 32'(pass1), 32'd0);

        // 4: start during a sweep is ignored.
        mode1 = 2'd0;
        push1(32, 0, 1'b1, 0);
        pulse_start1();
        wait_vec1(4'h5);
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("t4_busy_after_restart", 32'(busy1), 32'd1);
        wait_done1();
        @(negedge clk);

        // 5: asynchronous reset mid-sweep discards the partial result.
        mode1 = 2'd2;
        pulse_start1();
        wait_vec1(4'h7);
        chk("t5_err_before_rst", 32'(err1), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy1), 32'd0);
        chk("t5_rst_vec", 32'(vec1), 32'd0);
        chk("t5_rst_err", 32'(err1), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        mode1 = 2'd0;
        push1(32, 0, 1'b1, 0);
        pulse_start1();
        chk("t5_new_sweep_vec", 32'(vec1), 32'd0);
        chk("t5_new_sweep_busy", 32'(busy1), 32'd1);
        wait_done1();
        @(negedge clk);

        // 6: SETTLE_CYC=3, start held so each DONE cycle launches the next sweep.
        push3(64, 0, 1'b1, 0);
        push3(64, 0, 1'b1, 0);
        push3(64, 0, 1'b1, 0);
        start3 = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            wait_done3();
            if (s == 2) begin
                start3 = 1'b0;
            end else begin
                @(negedge clk);
                chk("t6_resweep_busy", 32'(busy3), 32'd1);
                chk("t6_resweep_vec", 32'(vec3), 32'd0);
                chk("t6_done_one_cycle", 32'(done3), 32'd0);
            end
        end
        repeat (2) @(negedge clk);
        chk("t6_stopped_busy", 32'(busy3), 32'd0);
        chk("t6_stopped_pass", 32'(pass3), 32'd1);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
